dht11_reader: RTL and testbench



---
 rtl/tusca_pkg.sv | 30 +++
 rtl/dht11_reader_if.sv | 21 ++
 rtl/dht11_sync.sv | 34 +++
 rtl/dht11_reader.sv | 135 +++++++++++++
 tb/tb_dht11_reader.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tusca_pkg.sv
// Shared TUSCA definitions: DHT11 reader FSM state codes, default 50 MHz
// timing constants and the frame checksum rule.
package tusca_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_RESP = 3'd2,
    ST_RESP_LOW  = 3'd3,
    ST_RESP_HIGH = 3'd4,
    ST_BIT_LOW   = 3'd5,
    ST_BIT_HIGH  = 3'd6,
    ST_FIM       = 3'd7
  } dht_state_e;

  localparam int unsigned DEF_START_LOW_CYCLES     = 1_000_000;
  localparam int unsigned DEF_BIT_THRESHOLD_CYCLES = 2_500;
  localparam int unsigned DEF_PHASE_TIMEOUT_CYCLES = 10_000;

  localparam int unsigned WIDTH_BITS = 20;
  localparam int unsigned FRAME_BITS = 40;

  // Frame is {hum_int, hum_dec, temp_int, temp_dec, check}; the sum wraps at 8 bits.
  function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return (sum == frame[7:0]);
  endfunction

endpackage

// File: rtl/dht11_reader_if.sv
// Control-unit side of the DHT11 reader: start request, results and status.
interface dht11_reader_if;

  logic        medir;
  logic [15:0] temperatura;
  logic [15:0] umidade;
  logic        pronto;
  logic        erro;
  logic [2:0]  db_estado;

  modport master (
    output medir,
    input  temperatura, umidade, pronto, erro, db_estado
  );

  modport slave (
    input  medir,
    output temperatura, umidade, pronto, erro, db_estado
  );

endinterface

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the sensor line plus a previous-sample register
// that turns the synchronized level into single-cycle rise/fall strobes.
module dht11_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_bus,
  output logic o_sobe,
  output logic o_desce
);

  logic r_meta;
  logic r_bus_s;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so each flop samples
  // the pre-edge value of the one before it.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: reset to the pulled-up idle level so leaving reset never looks
      // like a falling edge on the line.
      r_meta  <= 1'b1;
      r_bus_s <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_meta  <= i_bus;
      r_bus_s <= r_meta;
      r_prev  <= r_bus_s;
    end
  end

  assign o_sobe  = r_bus_s & ~r_prev;
  assign o_desce = ~r_bus_s & r_prev;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 acquisition engine: host start pulse, response/bit decoding by
// high-phase width, checksum validation and per-phase timeout.
module dht11_reader
  import tusca_pkg::*;
#(
  parameter int unsigned START_LOW_CYCLES     = DEF_START_LOW_CYCLES,
  parameter int unsigned BIT_THRESHOLD_CYCLES = DEF_BIT_THRESHOLD_CYCLES,
  parameter int unsigned PHASE_TIMEOUT_CYCLES = DEF_PHASE_TIMEOUT_CYCLES
) (
  input  logic          clock,
  input  logic          reset,
  dht11_reader_if.slave bus_if,
  inout  wire           dht_bus
);

  // r_width counts cycles already spent in the state, so the phase length
  // including the current cycle is r_width + 1.
  localparam logic [WIDTH_BITS-1:0] START_LAST   = WIDTH_BITS'(START_LOW_CYCLES - 1);
  localparam logic [WIDTH_BITS-1:0] BIT_ONE_MIN  = WIDTH_BITS'(BIT_THRESHOLD_CYCLES);
  localparam logic [WIDTH_BITS-1:0] TIMEOUT_LAST = WIDTH_BITS'(PHASE_TIMEOUT_CYCLES - 1);
  localparam logic [5:0]            LAST_BIT     = 6'(FRAME_BITS - 1);

  dht_state_e            r_state;
  dht_state_e            w_next;
  logic [WIDTH_BITS-1:0] r_width;
  logic [5:0]            r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_drive_low;
  logic [15:0]           r_temperatura;
  logic [15:0]           r_umidade;
  logic                  r_pronto;
  logic                  r_erro;

  logic                  w_sobe;
  logic                  w_desce;
  logic                  w_bit;
  logic                  w_shift;
  logic                  w_timeout;
  logic [FRAME_BITS-1:0] w_frame;

  dht11_sync u_sync (
    .clock   (clock),
    .reset   (reset),
    .i_bus   (dht_bus),
    .o_sobe  (w_sobe),
    .o_desce (w_desce)
  );

  assign w_bit   = (r_width >= BIT_ONE_MIN);
  assign w_frame = {r_shift[FRAME_BITS-2:0], w_bit};

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    w_shift   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE:      if (bus_if.medir) w_next = ST_START;
      ST_START:     if (r_width >= START_LAST) w_next = ST_WAIT_RESP;
      ST_WAIT_RESP: if (w_desce) w_next = ST_RESP_LOW;
      ST_RESP_LOW:  if (w_sobe)  w_next = ST_RESP_HIGH;
      ST_RESP_HIGH: if (w_desce) w_next = ST_BIT_LOW;
      ST_BIT_LOW:   if (w_sobe)  w_next = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (w_desce) begin
          w_shift = 1'b1;
          w_next  = (r_bit_cnt == LAST_BIT) ? ST_FIM : ST_BIT_LOW;
        end
      end
      ST_FIM:       w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    // Edge-driven states only: the start pulse is host-timed and never times out.
    if ((r_state inside {ST_WAIT_RESP, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH})
        && (w_next == r_state) && (r_width >= TIMEOUT_LAST)) begin
      w_timeout = 1'b1;
      w_next    = ST_FIM;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_width       <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_drive_low   <= 1'b0;
      r_temperatura <= '0;
      r_umidade     <= '0;
      r_pronto      <= 1'b0;
      r_erro        <= 1'b0;
    end else begin
      r_pronto    <= 1'b0;
      r_drive_low <= (w_next == ST_START);

      if (w_next != r_state)   r_width <= '0;
      else if (r_width != '1) r_width <= r_width + WIDTH_BITS'(1);

      if ((r_state == ST_IDLE) && bus_if.medir) begin
        r_erro    <= 1'b0;
        r_bit_cnt <= '0;
      end

      if (w_shift) begin
        r_shift   <= w_frame;
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end

      // Results are registered on FIM entry so they are valid alongside pronto.
      if (w_next == ST_FIM) begin
        r_pronto <= 1'b1;
        if (!w_timeout && checksum_ok(w_frame)) begin
          r_umidade     <= w_frame[39:24];
          r_temperatura <= w_frame[23:8];
        end else begin
          r_erro <= 1'b1;
        end
      end
    end
  end

  assign dht_bus = r_drive_low ? 1'b0 : 1'bz;

  assign bus_if.temperatura = r_temperatura;
  assign bus_if.umidade     = r_umidade;
  assign bus_if.pronto      = r_pronto;
  assign bus_if.erro        = r_erro;
  assign bus_if.db_estado   = r_state;

endmodule

// File: tb/tb_dht11_reader.sv
// Scoreboard bench for dht11_reader: a behavioural sensor drives randomized
// frames; expected results are queued and checked when pronto is seen.
module tb_dht11_reader;
  import tusca_pkg::*;

  localparam int START_LOW = 100;
  localparam int THRESH    = 25;
  localparam int TIMEOUT   = 100;

  typedef struct packed {
    logic [15:0] temp;
    logic [15:0] umid;
    logic        erro;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic sensor_low;
  wire  dht_bus;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pronto = 0;
  exp_t sb[$];
  logic [15:0] m_temp = '0;
  logic [15:0] m_umid = '0;

  dht11_reader_if dif ();

  always #5 clock = ~clock;

  assign dht_bus = sensor_low ? 1'b0 : 1'bz;
  pullup (dht_bus);

  dht11_reader #(
    .START_LOW_CYCLES     (START_LOW),
    .BIT_THRESHOLD_CYCLES (THRESH),
    .PHASE_TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus_if  (dif),
    .dht_bus (dht_bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a complete frame with a matching byte sum updates the
  // stored readings; anything else reports an error and keeps them.
  task automatic expect_result(input logic [39:0] frame, input bit complete);
    int   sum;
    exp_t e;
    sum = (int'(frame[39:32]) + int'(frame[31:24]) + int'(frame[23:16]) + int'(frame[15:8])) % 256;
    if (complete && sum == int'(frame[7:0])) begin
      m_umid = frame[39:24];
      m_temp = frame[23:8];
      e.erro = 1'b0;
    end else begin
      e.erro = 1'b1;
    end
    e.temp = m_temp;
    e.umid = m_umid;
    sb.push_back(e);
  endtask

  function automatic logic [39:0] make_frame(input bit good);
    logic [7:0] b0, b1, b2, b3, ck;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    b3 = 8'($urandom);
    ck = b0 + b1 + b2 + b3;
    if (!good) ck = ck ^ (8'(1) << $urandom_range(7, 0));
    return {b0, b1, b2, b3, ck};
  endfunction

  task automatic hold(input bit low, input int n);
    sensor_low = low;
    repeat (n) @(negedge clock);
  endtask

  // Pulse medir and time the host start pulse; returns at the first released sample.
  task automatic host_start();
    int lows;
    @(negedge clock); dif.medir = 1'b1;
    @(negedge clock); dif.medir = 1'b0;
    check("bus low after medir", 32'(dht_bus), 0);
    lows = 0;
    while (dht_bus === 1'b0 && lows < 10 * START_LOW) begin
      lows++;
      @(negedge clock);
    end
    check("start low length", lows, START_LOW);
  endtask

  task automatic run_measure(input logic [39:0] frame, input int nbits,
                             input bit exact, input bit check_lat);
    int hi;
    int k;
    bit seen;
    host_start();
    hold(1'b0, $urandom_range(30, 5));
    hold(1'b1, $urandom_range(40, 30));
    hold(1'b0, $urandom_range(40, 30));
    for (int i = 0; i < nbits; i++) begin
      if (exact) hi = frame[39-i] ? THRESH + 1 : THRESH;
      else       hi = frame[39-i] ? $urandom_range(70, THRESH + 1) : $urandom_range(THRESH, 5);
      hold(1'b1, $urandom_range(20, 8));
      hold(1'b0, hi);
    end
    sensor_low = 1'b1;
    k = 0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      k++;
      if (!seen && dif.pronto === 1'b1) begin
        seen = 1'b1;
        if (check_lat) check("pronto latency after last fall", k, 3);
      end
    end
    if (check_lat) check("pronto during final low", 32'(seen), 1);
    sensor_low = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check("result within bound", sb.size(), 0);
    repeat (20) @(negedge clock);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int k;
    reset      = 1'b1;
    sensor_low = 1'b0;
    dif.medir  = 1'b0;

    fork
      begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
          @(negedge clock);
          if (dif.pronto === 1'b1) begin
            n_pronto++;
            check("pronto single cycle", 32'(prev), 0);
            check("pronto expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("temperatura", dif.temperatura, e.temp);
              check("umidade", dif.umidade, e.umid);
              check("erro", 32'(dif.erro), 32'(e.erro));
              check("state at pronto", dif.db_estado, ST_FIM);
            end
          end
          prev = dif.pronto;
        end
      end
    join_none

    repeat (5) @(negedge clock);
    check("reset temperatura", dif.temperatura, 0);
    check("reset umidade", dif.umidade, 0);
    check("reset pronto", 32'(dif.pronto), 0);
    check("reset erro", 32'(dif.erro), 0);
    check("reset state", dif.db_estado, ST_IDLE);
    check("reset bus released", 32'(dht_bus), 1);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Reference frame, then the same frame with a bad checksum.
    expect_result(40'h37_00_19_05_55, 1'b1);
    run_measure(40'h37_00_19_05_55, 40, 1'b0, 1'b1);
    wait_done();
    expect_result(40'h37_00_19_05_54, 1'b1);
    run_measure(40'h37_00_19_05_54, 40, 1'b0, 1'b1);
    wait_done();

    // Silent sensor: timeout counted from the bus release.
    expect_result(40'h0, 1'b0);
    host_start();
    k = 0;
    while (dif.pronto !== 1'b1 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    check("silent timeout latency", k, TIMEOUT);
    @(negedge clock);
    check("state after timeout", dif.db_estado, ST_IDLE);
    wait_done();

    // Sensor stops after bit 17, then a good frame clears the error.
    expect_result(40'hA5_5A_C3_3C_00, 1'b0);
    run_measure(40'hA5_5A_C3_3C_00, 18, 1'b0, 1'b0);
    wait_done();
    begin
      logic [39:0] f;
      f = make_frame(1'b1);
      expect_result(f, 1'b1);
      run_measure(f, 40, 1'b0, 1'b1);
      wait_done();
    end

    // medir pulsed repeatedly mid-transfer must be ignored.
    p0 = n_pronto;
    begin
      logic [39:0] f;
      f = make_frame(1'b1);
      expect_result(f, 1'b1);
      fork
        run_measure(f, 40, 1'b0, 1'b1);
        begin
          repeat (200) @(negedge clock);
          repeat (10) begin
            dif.medir = 1'b1;
            @(negedge clock);
            dif.medir = 1'b0;
            repeat (20) @(negedge clock);
          end
        end
      join
      wait_done();
      repeat (300) @(negedge clock);
      check("one pronto despite medir spam", n_pronto, p0 + 1);
    end

    // Reset while driving the start pulse releases the bus immediately.
    @(negedge clock); dif.medir = 1'b1;
    @(negedge clock); dif.medir = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("bus released after reset", 32'(dht_bus), 1);
    check("state after reset in START", dif.db_estado, ST_IDLE);
    check("temperatura cleared by reset", dif.temperatura, 0);
    check("umidade cleared by reset", dif.umidade, 0);
    reset  = 1'b0;
    m_temp = '0;
    m_umid = '0;
    repeat (5) @(negedge clock);

    // Reset during BIT_HIGH: no pronto for the aborted measurement.
    p0 = n_pronto;
    fork
      run_measure(make_frame(1'b1), 40, 1'b0, 1'b0);
      begin
        int w;
        w = 0;
        while (dif.db_estado !== ST_BIT_HIGH && w < 2000) begin
          @(negedge clock);
          w++;
        end
        check("reached BIT_HIGH", dif.db_estado, ST_BIT_HIGH);
        reset = 1'b1;
        @(negedge clock);
        check("state after reset in BIT_HIGH", dif.db_estado, ST_IDLE);
        check("no pronto on reset", 32'(dif.pronto), 0);
        check("erro cleared by reset", 32'(dif.erro), 0);
        reset = 1'b0;
      end
    join
    repeat (300) @(negedge clock);
    check("no pronto after aborted measurement", n_pronto, p0);

    // Threshold widths 25 -> 0 and 26 -> 1, including checksum wrap-around.
    expect_result(40'hFF_FF_FF_FF_FC, 1'b1);
    run_measure(40'hFF_FF_FF_FF_FC, 40, 1'b1, 1'b1);
    wait_done();
    expect_result(40'h12_34_56_78_14, 1'b1);
    run_measure(40'h12_34_56_78_14, 40, 1'b1, 1'b1);
    wait_done();

    // Random frames, some with a corrupted checksum.
    for (int i = 0; i < 5; i++) begin
      logic [39:0] f;
      f = make_frame($urandom_range(3, 0) != 0);
      expect_result(f, 1'b1);
      run_measure(f, 40, 1'b0, 1'b1);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
